// File: rtl/daq_uart_pkg.sv
// Shared types and constants for the DAQ UART transmitter.
// Frame-length helper lets users size timeouts around one frame.
package daq_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_START    = 3'd1;
    localparam state_t ST_DATA     = 3'd2;
    localparam state_t ST_PARITY   = 3'd3;
    localparam state_t ST_STOP     = 3'd4;
    localparam state_t ST_WAIT_LOW = 3'd5;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int frame_clks(int cpb, int parity, int stop_bits);
        return (10 + ((parity != PARITY_NONE) ? 1 : 0)
                + (stop_bits - 1)) * cpb;
    endfunction

    function automatic logic parity_bit(int mode, logic [7:0] f);
        return (mode == PARITY_ODD) ? ~^f : ^f;
    endfunction

endpackage

// File: rtl/daq_uart_if.sv
// Four-phase DAQ readout handshake between producer and UART.
// data_ready/data are driven asynchronously by the producer.
interface daq_uart_if;

    logic       data_ready;
    logic [6:0] data;
    logic       data_loaded;

    modport master (
        output data_ready,
        output data,
        input  data_loaded
    );

    modport slave (
        input  data_ready,
        input  data,
        output data_loaded
    );

endinterface

// File: rtl/daq_baud_gen.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 while run is high.
// bit_tick marks the last clk of each bit period.
module daq_baud_gen #(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bit_tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign bit_tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/daq_uart_tx.sv
// UART transmitter for DAQ bytes framed as {MARK_BIT, data[6:0]}.
// One byte per data_ready/data_loaded four-phase handshake.
module daq_uart_tx
    import daq_uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 347,
    parameter int   PARITY       = PARITY_NONE,
    parameter int   STOP_BITS    = 1,
    parameter logic MARK_BIT     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    daq_uart_if.slave   bus,
    output logic        txd,
    output logic        busy
);

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t     state;
    logic       rdy_q1;
    logic       rdy_s;
    logic [7:0] shreg;
    logic       par;
    logic [2:0] bit_cnt;
    logic       run;
    logic       bit_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q1 <= 1'b0;
            rdy_s  <= 1'b0;
        end else begin
            rdy_q1 <= bus.data_ready;
            rdy_s  <= rdy_q1;
        end
    end

    assign run = (state == ST_START) || (state == ST_DATA) ||
                 (state == ST_PARITY) || (state == ST_STOP);

    daq_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            shreg           <= '0;
            par             <= 1'b0;
            bit_cnt         <= '0;
            bus.data_loaded <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rdy_s) begin
                        shreg           <= {MARK_BIT, bus.data};
                        par             <= parity_bit(PARITY,
                                                      {MARK_BIT, bus.data});
                        bus.data_loaded <= 1'b1;
                        bit_cnt         <= '0;
                        state           <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY
                                                             : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bus.data_loaded <= 1'b0;
                            bit_cnt         <= '0;
                            state           <= ST_WAIT_LOW;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    // a producer slow to drop ready must not get a repeat frame
                    if (!rdy_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        txd = 1'b1;
        unique case (state)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = shreg[0];
            ST_PARITY: txd = par;
            default:   txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_daq_uart_tx.sv
// Directed bench for daq_uart_tx: three instances (no/even/odd parity)
// share one producer and are sampled mid-bit at CLKS_PER_BIT=4.
module tb_daq_uart_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ready;
    logic [6:0] data;

    logic txd0, txde, txdo;
    logic busy0, busye, busyo;
    logic dl0, dle, dlo;

    int errs   = 0;
    int checks = 0;

    logic [10:0] r_b0, r_be, r_bo;
    int          r_lat;
    logic        r_dl39, r_dl40;

    logic dl0_q = 1'b0;
    int   rise_cnt = 0;

    always #5 clk = ~clk;

    daq_uart_if bus0 ();
    daq_uart_if buse ();
    daq_uart_if buso ();

    assign bus0.data_ready = ready;
    assign bus0.data       = data;
    assign buse.data_ready = ready;
    assign buse.data       = data;
    assign buso.data_ready = ready;
    assign buso.data       = data;
    assign dl0 = bus0.data_loaded;
    assign dle = buse.data_loaded;
    assign dlo = buso.data_loaded;

    daq_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .txd(txd0), .busy(busy0)
    );

    daq_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1)) u_even (
        .clk(clk), .reset_n(reset_n), .bus(buse),
        .txd(txde), .busy(busye)
    );

    daq_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2)) u_odd (
        .clk(clk), .reset_n(reset_n), .bus(buso),
        .txd(txdo), .busy(busyo)
    );

    always @(posedge clk) begin
        dl0_q <= dl0;
        if (dl0 && !dl0_q) rise_cnt <= rise_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // t=0 is the first negedge with data_loaded high (first START clk);
    // bit k is sampled at t=4k+2.
    task automatic send(input logic [6:0] d, input bit hold,
                        input int rst_at, input int chg_at);
        int n;
        bit seen;
        n = 0;
        while ((busy0 || busye || busyo) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("idle_timeout", {29'd0, busy0, busye, busyo}, 0);
            return;
        end
        @(negedge clk);
        data  = d;
        ready = 1'b1;
        r_b0 = '1; r_be = '1; r_bo = '1;
        r_dl39 = 1'b0; r_dl40 = 1'b1;
        seen = 1'b0;
        for (r_lat = 1; r_lat <= 50; r_lat++) begin
            @(negedge clk);
            if (dl0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("loaded_timeout", dl0, 1);
            ready = 1'b0;
            return;
        end
        for (int t = 0; t <= 44; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 0 && !hold) ready = 1'b0;
            if (t == chg_at) data = 7'h7F;
            if (t == rst_at) begin
                chk("pre_rst_txd", txd0, 0);
                reset_n = 1'b0;
                #1;
                chk("rst_txd", txd0, 1);
                chk("rst_loaded", dl0, 0);
                chk("rst_busy", busy0, 0);
                break;
            end
            if (t % 4 == 2) begin
                r_b0[t/4] = txd0;
                r_be[t/4] = txde;
                r_bo[t/4] = txdo;
            end
            if (t == 39) r_dl39 = dl0;
            if (t == 40) r_dl40 = dl0;
        end
    endtask

    initial begin
        int extra;
        logic [6:0] d;

        reset_n = 1'b0;
        ready   = 1'b0;
        data    = 7'h00;
        repeat (3) @(negedge clk);
        chk("reset_txd", txd0, 1);
        chk("reset_loaded", dl0, 0);
        chk("reset_busy", busy0, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: basic frame 0x55 -> 8'hD5 on the line
        send(7'h55, 1'b0, -1, -1);
        chk("t1_latency", r_lat, 3);
        chk("t1_start", r_b0[0], 0);
        chk("t1_data", r_b0[8:1], 8'hD5);
        chk("t1_stop", r_b0[9], 1);
        chk("t1_loaded_last_stop", r_dl39, 1);
        chk("t1_loaded_clear", r_dl40, 0);

        // 2: ready held high -> one frame, then WAIT_LOW
        send(7'h01, 1'b1, -1, -1);
        chk("t2_data", r_b0[8:1], 8'h81);
        extra = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (dl0 || !txd0) extra++;
        end
        chk("t2_no_second_frame", extra, 0);
        chk("t2_wait_low_busy", busy0, 1);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_busy_sync", busy0, 1);
        @(negedge clk);
        chk("t2_idle", busy0, 0);

        // 3: parity over frame 8'h83
        send(7'h03, 1'b0, -1, -1);
        chk("t3_latency", r_lat, 3);
        chk("t3_even_data", r_be[8:1], 8'h83);
        chk("t3_even_par", r_be[9], 1);
        chk("t3_odd_par", r_bo[9], 0);
        chk("t3_even_stop", r_be[10], 1);
        chk("t3_none_stop", r_b0[9], 1);

        // 4: reset during data bit 4 (frame 8'h8F, bit 4 = 0)
        send(7'h0F, 1'b0, 21, -1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(7'h2A, 1'b0, -1, -1);
        chk("t4_after_rst", r_b0[8:1], 8'hAA);
        chk("t4_start", r_b0[0], 0);
        chk("t4_stop", r_b0[9], 1);

        // 5: data changes after capture
        send(7'h11, 1'b0, -1, 8);
        chk("t5_data", r_b0[8:1], 8'h91);

        // 6: byte stream
        extra = rise_cnt;
        for (int i = 0; i < 1024; i++) begin
            d = 7'((i * 37 + 5) & 127);
            send(d, 1'b0, -1, -1);
            chk("t6_stream", r_b0[8:1], {1'b1, d});
        end
        repeat (4) @(negedge clk);
        chk("t6_rises", rise_cnt - extra, 1024);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
